// File: rtl/aha_tlx_pkg.sv
// Shared TLX monitor types: FSM encoding and datapath widths, also used by the output capsule.
package aha_tlx_pkg;

    localparam int TLX_WORD_W  = 32;
    localparam int TLX_ERR_W   = 16;
    localparam int TLX_PHASE_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCK   = 2'd2,
        ST_FINISH = 2'd3
    } tlx_state_e;

endpackage

// File: rtl/aha_tlx_training_monitor_if.sv
// Signal bundle for the training monitor: lane/config inputs and status outputs.
// ERR_LIMIT exists only when AHA_TLX_MON_ERR_LIMIT_EN is defined.
interface aha_tlx_training_monitor_if
    import aha_tlx_pkg::*;
(
    input logic CLK
);
    logic                  D_IN;
    logic                  START;
    logic                  CLEAR;
    logic [TLX_WORD_W-1:0] SEQUENCE;
    logic [TLX_WORD_W-1:0] LENGTH;
    logic                  AUTO_STOP;
    logic                  MODE;
`ifdef AHA_TLX_MON_ERR_LIMIT_EN
    logic [TLX_ERR_W-1:0]  ERR_LIMIT;
`endif
    logic                  D_OUT;
    logic                  LOCKED;
    logic                  DONE;
    logic                  ACTIVE;
    logic [TLX_WORD_W-1:0] MATCH_COUNT;
    logic [TLX_ERR_W-1:0]  ERR_COUNT;

    modport master (
        input  CLK,
        output D_IN, START, CLEAR, SEQUENCE, LENGTH, AUTO_STOP, MODE,
`ifdef AHA_TLX_MON_ERR_LIMIT_EN
        output ERR_LIMIT,
`endif
        input  D_OUT, LOCKED, DONE, ACTIVE, MATCH_COUNT, ERR_COUNT
    );

    modport slave (
        input  CLK,
        input  D_IN, START, CLEAR, SEQUENCE, LENGTH, AUTO_STOP, MODE,
`ifdef AHA_TLX_MON_ERR_LIMIT_EN
        input  ERR_LIMIT,
`endif
        output D_OUT, LOCKED, DONE, ACTIVE, MATCH_COUNT, ERR_COUNT
    );

endinterface

// File: rtl/aha_sync_pulse_gen.sv
// Registered rising-edge detector: one-cycle pulse, one cycle after a 0->1 on i_d.
// History resets to "not seen low", so a level held high through reset never pulses.
module AhaSyncPulseGen (
    input  logic CLK,
    input  logic RESETn,
    input  logic i_d,
    output logic o_pulse
);
    logic r_was_low;
    logic r_pulse;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_was_low <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_was_low <= ~i_d;
            r_pulse   <= i_d & r_was_low;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/aha_tlx_training_monitor.sv
// Serial TLX training-word monitor: search/lock on an LSB-first word, count matches/errors.
// START/CLEAR act 1 cycle after their edge; no backpressure. AHA_TLX_MON_ERR_LIMIT_EN adds ERR_LIMIT relock.
module aha_tlx_training_monitor
    import aha_tlx_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  D_IN,
    input  logic                  START,
    input  logic                  CLEAR,
    input  logic [TLX_WORD_W-1:0] SEQUENCE,
    input  logic [TLX_WORD_W-1:0] LENGTH,
    input  logic                  AUTO_STOP,
    input  logic                  MODE,
`ifdef AHA_TLX_MON_ERR_LIMIT_EN
    input  logic [TLX_ERR_W-1:0]  ERR_LIMIT,
`endif
    output logic                  D_OUT,
    output logic                  LOCKED,
    output logic                  DONE,
    output logic                  ACTIVE,
    output logic [TLX_WORD_W-1:0] MATCH_COUNT,
    output logic [TLX_ERR_W-1:0]  ERR_COUNT
);
    localparam logic [TLX_PHASE_W-1:0] PH_LAST = '1;

    tlx_state_e             r_state, w_state_nxt;
    logic [TLX_WORD_W-1:1]  r_sh, w_sh_nxt;
    logic [TLX_PHASE_W-1:0] r_fill, w_fill_nxt;
    logic [TLX_PHASE_W-1:0] r_phase, w_phase_nxt;
    logic [TLX_WORD_W-1:0]  r_match, w_match_nxt;
    logic [TLX_ERR_W-1:0]   r_err, w_err_nxt;
    logic                   r_done, w_done_nxt;
    logic                   w_start_pulse, w_clear_pulse;
    logic                   w_hit;
    logic [TLX_WORD_W-1:0]  w_word;
    logic [TLX_ERR_W-1:0]   w_err_inc;

    AhaSyncPulseGen u_start_edge (.CLK(CLK), .RESETn(RESETn), .i_d(START), .o_pulse(w_start_pulse));
    AhaSyncPulseGen u_clear_edge (.CLK(CLK), .RESETn(RESETn), .i_d(CLEAR), .o_pulse(w_clear_pulse));

    // bit 0 of the stored window is never needed: the next word is the new bit plus the top 31
    assign w_word    = {D_IN, r_sh};
    assign w_err_inc = r_err + TLX_ERR_W'(1);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_fill_nxt  = r_fill;
        w_phase_nxt = r_phase;
        w_match_nxt = r_match;
        w_err_nxt   = r_err;
        w_done_nxt  = r_done;
        w_hit       = 1'b0;
        if (w_clear_pulse) begin
            w_state_nxt = ST_IDLE;
            w_sh_nxt    = '0;
            w_fill_nxt  = '0;
            w_phase_nxt = '0;
            w_match_nxt = '0;
            w_err_nxt   = '0;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_pulse) begin
                        w_state_nxt = ST_SEARCH;
                        w_fill_nxt  = '0;
                        w_match_nxt = '0;
                        w_err_nxt   = '0;
                    end
                end
                ST_SEARCH: begin
                    w_sh_nxt   = w_word[TLX_WORD_W-1:1];
                    w_fill_nxt = (r_fill == PH_LAST) ? r_fill : r_fill + TLX_PHASE_W'(1);
                    if (r_fill == PH_LAST && w_word == SEQUENCE) begin
                        w_state_nxt = ST_LOCK;
                        w_phase_nxt = '0;
                        w_hit       = 1'b1;
                    end
                end
                ST_LOCK: begin
                    w_sh_nxt    = w_word[TLX_WORD_W-1:1];
                    w_phase_nxt = r_phase + TLX_PHASE_W'(1);
                    if (r_phase == PH_LAST) begin
                        if (w_word == SEQUENCE) begin
                            w_hit = 1'b1;
                        end else if (r_err != '1) begin
                            w_err_nxt = w_err_inc;
`ifdef AHA_TLX_MON_ERR_LIMIT_EN
                            if (ERR_LIMIT != '0 && w_err_inc == ERR_LIMIT) begin
                                w_state_nxt = ST_SEARCH;
                                w_fill_nxt  = '0;
                            end
`endif
                        end
                    end
                end
                default: ;
            endcase
            if (w_hit) begin
                w_match_nxt = (r_match == '1) ? r_match : r_match + TLX_WORD_W'(1);
                if (AUTO_STOP && w_match_nxt >= LENGTH) begin
                    w_state_nxt = ST_FINISH;
                    w_done_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_sh    <= '0;
            r_fill  <= '0;
            r_phase <= '0;
            r_match <= '0;
            r_err   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_sh    <= w_sh_nxt;
            r_fill  <= w_fill_nxt;
            r_phase <= w_phase_nxt;
            r_match <= w_match_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign D_OUT       = MODE ? 1'b0 : D_IN;
    assign LOCKED      = (r_state == ST_LOCK);
    assign ACTIVE      = (r_state == ST_SEARCH) || (r_state == ST_LOCK);
    assign DONE        = r_done;
    assign MATCH_COUNT = r_match;
    assign ERR_COUNT   = r_err;

endmodule
